// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline register chain.
package pipe_pkg;

  localparam int WORD_WIDTH = 32;
  localparam logic [WORD_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic                  valid;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline register slot: clear wins over load; an invalid source only
// drops the valid bit so the payload keeps its last value.
module pipe_reg_slot
  import pipe_pkg::*;
#(
  parameter int                     PC_WIDTH    = WORD_WIDTH,
  parameter int                     INSTR_WIDTH = WORD_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] RESET_INSTR = INSTR_WIDTH'(NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load,
  input  logic                   src_valid,
  input  logic [PC_WIDTH-1:0]    src_pc,
  input  logic [INSTR_WIDTH-1:0] src_instr,
  output logic                   valid,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] instr
);

  logic                   valid_reg;
  logic [PC_WIDTH-1:0]    pc_reg;
  logic [INSTR_WIDTH-1:0] instr_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= RESET_INSTR;
    end else if (load) begin
      valid_reg <= src_valid;
      if (src_valid) begin
        pc_reg    <= src_pc;
        instr_reg <= src_instr;
      end
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-slot pipeline register with valid/ready backpressure, bubble
// collapsing, freeze and flush. Define PIPE_REG_CHAIN_PERF_EN for perf counters.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int                     PC_WIDTH    = WORD_WIDTH,
  parameter int                     INSTR_WIDTH = WORD_WIDTH,
  parameter int                     DEPTH       = 1,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(pipe_pkg::NOP_INSTR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [PC_WIDTH-1:0]    in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   out_ready
`ifdef PIPE_REG_CHAIN_PERF_EN
  ,
  output logic [31:0]            perf_xfer_cnt,
  output logic [31:0]            perf_stall_cnt,
  output logic [31:0]            perf_flush_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be in 1..8");
  end

  logic [DEPTH-1:0]       slot_valid;
  logic [PC_WIDTH-1:0]    slot_pc    [DEPTH];
  logic [INSTR_WIDTH-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0]       src_valid;
  logic [PC_WIDTH-1:0]    src_pc     [DEPTH];
  logic [INSTR_WIDTH-1:0] src_instr  [DEPTH];
  logic [DEPTH-1:0]       adv;
  logic [DEPTH-1:0]       load;
  logic                   hold_all;

  assign hold_all = freeze | flush;

  // A slot may advance if it is empty or its successor advances; an empty
  // slot is therefore always fillable and bubbles close under a stall.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~slot_valid[DEPTH-1] | out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = ~slot_valid[k] | adv[k+1];
    end
  end

  assign in_ready  = adv[0] & ~hold_all;
  assign out_valid = slot_valid[DEPTH-1] & ~hold_all;
  assign out_pc    = slot_pc[DEPTH-1];
  assign out_instr = slot_instr[DEPTH-1];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    if (gi == 0) begin : g_src_in
      assign src_valid[gi] = in_valid & in_ready;
      assign src_pc[gi]    = in_pc;
      assign src_instr[gi] = in_instr;
    end else begin : g_src_prev
      assign src_valid[gi] = slot_valid[gi-1];
      assign src_pc[gi]    = slot_pc[gi-1];
      assign src_instr[gi] = slot_instr[gi-1];
    end

    assign load[gi] = adv[gi] & ~hold_all;

    pipe_reg_slot #(
      .PC_WIDTH   (PC_WIDTH),
      .INSTR_WIDTH(INSTR_WIDTH),
      .RESET_INSTR(NOP_INSTR)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (flush),
      .load     (load[gi]),
      .src_valid(src_valid[gi]),
      .src_pc   (src_pc[gi]),
      .src_instr(src_instr[gi]),
      .valid    (slot_valid[gi]),
      .pc       (slot_pc[gi]),
      .instr    (slot_instr[gi])
    );
  end

`ifdef PIPE_REG_CHAIN_PERF_EN
  logic [31:0] perf_xfer_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flush_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_xfer_reg  <= '0;
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (out_valid && out_ready) perf_xfer_reg <= perf_xfer_reg + 32'd1;
      if ((slot_valid[DEPTH-1] && !out_ready) || freeze)
        perf_stall_reg <= perf_stall_reg + 32'd1;
      if (flush) perf_flush_reg <= perf_flush_reg + 32'd1;
    end
  end

  assign perf_xfer_cnt  = perf_xfer_reg;
  assign perf_stall_cnt = perf_stall_reg;
  assign perf_flush_cnt = perf_flush_reg;
`endif

endmodule
